// File: rtl/fetch_unit.sv
// Instruction fetch sequencer: walks the program counter through a synchronous
// instruction memory and hands each word to the control unit until a halt word.
module fetch_unit #(
  parameter int          ADDR_W    = 8,
  parameter int          MEM_LAT   = 1,
  parameter logic [15:0] HALT_WORD = 16'hFFFF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic              pause,
  input  logic [15:0]       mem_rdata,
  input  logic              done,
  output logic              mem_rd,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [15:0]       instruction,
  output logic              run,
  output logic [ADDR_W-1:0] pc,
  output logic              busy,
  output logic              halted,
  output logic [15:0]       retired
);

  localparam int CNT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_REQ  = 3'd1,
    S_WAIT = 3'd2,
    S_EXEC = 3'd3,
    S_HALT = 3'd4
  } state_t;

  state_t            r_state;
  logic [ADDR_W-1:0] r_pc;
  logic [15:0]       r_instr;
  logic [15:0]       r_retired;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_run;
  logic              r_mem_rd;
  logic              r_busy;
  logic              r_halted;

  // Sequencer state machine; every output is a register so run drops on the done edge itself
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_pc      <= '0;
      r_instr   <= 16'h0000;
      r_retired <= 16'h0000;
      r_cnt     <= '0;
      r_run     <= 1'b0;
      r_mem_rd  <= 1'b0;
      r_busy    <= 1'b0;
      r_halted  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE, S_HALT: begin
          if (start) begin
            r_pc     <= start_addr;
            r_mem_rd <= 1'b1;
            r_busy   <= 1'b1;
            r_halted <= 1'b0;
            r_state  <= S_REQ;
          end
        end
        S_REQ: begin
          r_mem_rd <= 1'b0;
          r_cnt    <= CNT_W'(MEM_LAT - 1);
          r_state  <= S_WAIT;
        end
        S_WAIT: begin
          if (r_cnt != '0) begin
            r_cnt <= r_cnt - CNT_W'(1);
          end else if (mem_rdata == HALT_WORD) begin
            // Halt word is never issued: instruction and pc keep their values
            r_busy   <= 1'b0;
            r_halted <= 1'b1;
            r_state  <= S_HALT;
          end else begin
            r_instr <= mem_rdata;
            r_run   <= 1'b1;
            r_state <= S_EXEC;
          end
        end
        S_EXEC: begin
          if (done) begin
            r_run     <= 1'b0;
            r_pc      <= r_pc + ADDR_W'(1);
            r_retired <= r_retired + 16'd1;
            if (pause) begin
              r_busy  <= 1'b0;
              r_state <= S_IDLE;
            end else begin
              r_mem_rd <= 1'b1;
              r_state  <= S_REQ;
            end
          end
        end
        default: begin
          r_run    <= 1'b0;
          r_mem_rd <= 1'b0;
          r_busy   <= 1'b0;
          r_halted <= 1'b0;
          r_state  <= S_IDLE;
        end
      endcase
    end
  end

  assign mem_rd      = r_mem_rd;
  assign mem_addr    = r_pc;
  assign instruction = r_instr;
  assign run         = r_run;
  assign pc          = r_pc;
  assign busy        = r_busy;
  assign halted      = r_halted;
  assign retired     = r_retired;

endmodule

// File: tb/tb_fetch_unit.sv
// Randomized bench for fetch_unit: two instances (memory latency 1 and 3) run
// against a transaction-level model tracking expected pc, retire count and issued word.
module tb_fetch_unit;

  localparam int LAT0 = 1;
  localparam int LAT1 = 3;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic [1:0]       start_s, pause_s, done_s, mem_rd_s, run_s, busy_s, halted_s;
  logic [1:0][7:0]  start_addr_s, mem_addr_s, pc_s;
  logic [1:0][15:0] rdata_s, instr_s, retired_s;
  logic [15:0]      mem [256];
  logic [15:0]      p1a, p1b;

  int n_vec = 0;
  int n_err = 0;
  logic [7:0]  exp_pc    [2];
  logic [15:0] exp_ret   [2];
  logic [15:0] exp_instr [2];

  fetch_unit #(.ADDR_W(8), .MEM_LAT(LAT0), .HALT_WORD(16'hFFFF)) u_dut0 (
    .clk(clk), .reset(reset), .start(start_s[0]), .start_addr(start_addr_s[0]),
    .pause(pause_s[0]), .mem_rdata(rdata_s[0]), .done(done_s[0]),
    .mem_rd(mem_rd_s[0]), .mem_addr(mem_addr_s[0]), .instruction(instr_s[0]),
    .run(run_s[0]), .pc(pc_s[0]), .busy(busy_s[0]), .halted(halted_s[0]),
    .retired(retired_s[0])
  );

  fetch_unit #(.ADDR_W(8), .MEM_LAT(LAT1), .HALT_WORD(16'hFFFF)) u_dut1 (
    .clk(clk), .reset(reset), .start(start_s[1]), .start_addr(start_addr_s[1]),
    .pause(pause_s[1]), .mem_rdata(rdata_s[1]), .done(done_s[1]),
    .mem_rd(mem_rd_s[1]), .mem_addr(mem_addr_s[1]), .instruction(instr_s[1]),
    .run(run_s[1]), .pc(pc_s[1]), .busy(busy_s[1]), .halted(halted_s[1]),
    .retired(retired_s[1])
  );

  // Memory model: data appears exactly LAT cycles after a read strobe, garbage otherwise
  always @(posedge clk) begin
    rdata_s[0] <= mem_rd_s[0] ? mem[mem_addr_s[0]] : 16'hDEAD;
    p1a        <= mem_rd_s[1] ? mem[mem_addr_s[1]] : 16'hDEAD;
    p1b        <= p1a;
    rdata_s[1] <= p1b;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Called just after the edge that launched a fetch of exp_pc[k]
  task automatic fetch(input int k);
    int n;
    int lat;
    lat = (k == 0) ? LAT0 : LAT1;
    check("fetch_rd", 32'(mem_rd_s[k]), 32'd1);
    check("fetch_addr", 32'(mem_addr_s[k]), 32'(exp_pc[k]));
    n = 0;
    do begin
      tick();
      n++;
      if (n <= lat) check("fetch_rd_once", 32'(mem_rd_s[k]), 32'd0);
    end while (!run_s[k] && !halted_s[k] && n < 20);
    check("fetch_latency", 32'(n), 32'(lat + 1));
    if (mem[exp_pc[k]] == 16'hFFFF) begin
      check("halt_flag", 32'(halted_s[k]), 32'd1);
      check("halt_run", 32'(run_s[k]), 32'd0);
      check("halt_busy", 32'(busy_s[k]), 32'd0);
      check("halt_pc", 32'(pc_s[k]), 32'(exp_pc[k]));
      check("halt_retired", 32'(retired_s[k]), 32'(exp_ret[k]));
      check("halt_instr", 32'(instr_s[k]), 32'(exp_instr[k]));
    end else begin
      exp_instr[k] = mem[exp_pc[k]];
      check("issue_run", 32'(run_s[k]), 32'd1);
      check("issue_busy", 32'(busy_s[k]), 32'd1);
      check("issue_instr", 32'(instr_s[k]), 32'(exp_instr[k]));
    end
  endtask

  task automatic start_seq(input int k, input logic [7:0] addr);
    start_s[k]      = 1'b1;
    start_addr_s[k] = addr;
    pause_s[k]      = 1'($urandom_range(0, 1));
    tick();
    start_s[k] = 1'b0;
    pause_s[k] = 1'b0;
    exp_pc[k]  = addr;
    fetch(k);
  endtask

  task automatic retire(input int k, input logic p);
    int d;
    d = $urandom_range(0, 3);
    repeat (d) begin
      start_s[k]      = 1'($urandom_range(0, 1));
      start_addr_s[k] = 8'($urandom);
      pause_s[k]      = 1'($urandom_range(0, 1));
      tick();
      check("exec_run", 32'(run_s[k]), 32'd1);
      check("exec_pc", 32'(pc_s[k]), 32'(exp_pc[k]));
      check("exec_instr", 32'(instr_s[k]), 32'(exp_instr[k]));
    end
    start_s[k] = 1'b0;
    done_s[k]  = 1'b1;
    pause_s[k] = p;
    tick();
    done_s[k]  = 1'b0;
    pause_s[k] = 1'b0;
    exp_pc[k]  = exp_pc[k] + 8'd1;
    exp_ret[k] = exp_ret[k] + 16'd1;
    check("done_run", 32'(run_s[k]), 32'd0);
    check("done_pc", 32'(pc_s[k]), 32'(exp_pc[k]));
    check("done_retired", 32'(retired_s[k]), 32'(exp_ret[k]));
    if (p) begin
      check("pause_busy", 32'(busy_s[k]), 32'd0);
      check("pause_rd", 32'(mem_rd_s[k]), 32'd0);
      tick();
      check("pause_idle_rd", 32'(mem_rd_s[k]), 32'd0);
      check("pause_idle_run", 32'(run_s[k]), 32'd0);
    end else begin
      fetch(k);
    end
  endtask

  task automatic random_walk(input int k, input int iters);
    for (int it = 0; it < iters; it++) begin
      if (!run_s[k]) start_seq(k, 8'($urandom));
      else retire(k, 1'($urandom_range(0, 3) == 0));
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      mem[i] = 16'($urandom);
      if (mem[i] == 16'hFFFF) mem[i] = 16'h0000;
    end
    mem[8'h12] = 16'hFFFF;
    mem[8'hA0] = 16'hFFFF;
    mem[8'h10] = 16'h1010;
    mem[8'h11] = 16'h2011;
    mem[8'hFF] = 16'h1234;
    mem[8'h00] = 16'h5678;
    mem[8'h40] = 16'h4040;
    mem[8'h41] = 16'h4141;
    start_s = 2'b00; pause_s = 2'b00; done_s = 2'b00; start_addr_s = '0;
    for (int k = 0; k < 2; k++) begin
      exp_pc[k] = 8'h00; exp_ret[k] = 16'h0000; exp_instr[k] = 16'h0000;
    end
    reset = 1'b1;
    repeat (2) tick();
    reset = 1'b0;
    tick();
    for (int k = 0; k < 2; k++) begin
      check("rst_run", 32'(run_s[k]), 32'd0);
      check("rst_busy", 32'(busy_s[k]), 32'd0);
      check("rst_halted", 32'(halted_s[k]), 32'd0);
      check("rst_pc", 32'(pc_s[k]), 32'd0);
      check("rst_retired", 32'(retired_s[k]), 32'd0);
      check("rst_instr", 32'(instr_s[k]), 32'd0);
      check("rst_rd", 32'(mem_rd_s[k]), 32'd0);
    end

    // done outside EXEC changes nothing
    done_s[0] = 1'b1;
    tick();
    done_s[0] = 1'b0;
    check("idle_done_pc", 32'(pc_s[0]), 32'd0);
    check("idle_done_ret", 32'(retired_s[0]), 32'd0);
    check("idle_done_busy", 32'(busy_s[0]), 32'd0);

    // Directed program: 0x10, 0x11, then halt at 0x12
    start_seq(0, 8'h10);
    retire(0, 1'b0);
    retire(0, 1'b0);
    check("halted_at_12", 32'(halted_s[0]), 32'd1);
    check("halted_ret2", 32'(retired_s[0]), 32'd2);
    repeat (3) begin
      tick();
      check("halt_stays", 32'({run_s[0], busy_s[0], halted_s[0]}), 32'b001);
    end
    start_seq(0, 8'h00);
    random_walk(0, 40);

    // pc wraparound
    if (run_s[0]) retire(0, 1'b1);
    start_seq(0, 8'hFF);
    retire(0, 1'b0);
    check("wrap_pc", 32'(pc_s[0]), 32'd0);

    // Asynchronous reset between clock edges while executing
    check("pre_rst_run", 32'(run_s[0]), 32'd1);
    @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    check("arst_run", 32'(run_s[0]), 32'd0);
    check("arst_busy", 32'(busy_s[0]), 32'd0);
    check("arst_pc", 32'(pc_s[0]), 32'd0);
    check("arst_retired", 32'(retired_s[0]), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    for (int k = 0; k < 2; k++) begin
      exp_pc[k] = 8'h00; exp_ret[k] = 16'h0000; exp_instr[k] = 16'h0000;
    end

    // Three-cycle memory latency instance
    start_seq(1, 8'h40);
    retire(1, 1'b0);
    random_walk(1, 20);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
